pipe_share_arbiter: RTL and testbench

Round-robin scheduler that shares one fixed-latency processing pipeline (a chain of `pipeliner` stages or any block with constant LATENCY and no backpressure) among N_REQ requesters. It grants at most one request per cycle and drives the pipeline input. It tracks each in-flight item's requester ID in a tag delay line aligned with the pipeline, then steers the pipeline output back to the originating requester. Per-requester outstanding limits and a runtime enable mask bound occupancy.

---
 rtl/pipe_arb_pkg.sv | 29 ++
 rtl/tag_delay_line.sv | 32 +++
 rtl/pipe_share_arbiter.sv | 178 +++++++++++++++++
 tb/tb_pipe_share_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_arb_pkg.sv
// Shared types and helpers for the pipeline-sharing arbiter: tag payload
// carried alongside each in-flight item and the round-robin pointer step.
package pipe_arb_pkg;

  localparam int unsigned DEF_N_REQ   = 4;
  localparam int unsigned DEF_WIDTH   = 64;
  localparam int unsigned DEF_LATENCY = 3;
  localparam int unsigned DEF_MAX_OUT = 4;

  localparam int unsigned ID_W = (DEF_N_REQ > 2) ? $clog2(DEF_N_REQ) : 1;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } pipe_tag_t;

  // Index following idx in a ring of n requesters.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] idx,
                                              input int unsigned     n);
    logic [ID_W-1:0] nxt;
    if (32'(idx) + 32'd1 >= n) begin
      nxt = '0;
    end else begin
      nxt = ID_W'(32'(idx) + 32'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/tag_delay_line.sv
// Resettable shift register of requester tags; the head lines up with the
// output of the shared fixed-latency pipeline.
module tag_delay_line
  import pipe_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 3,
  parameter type         tag_t = pipe_tag_t
) (
  input  logic clk,
  input  logic rst_n,
  input  tag_t push_i,
  output tag_t head_o
);

  tag_t line_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      line_q[0] <= push_i;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

  assign head_o = line_q[DEPTH-1];

endmodule

// File: rtl/pipe_share_arbiter.sv
// Round-robin sharing of one fixed-latency, no-backpressure pipeline among
// N_REQ requesters, with tag-steered responses and per-requester credit limits.
module pipe_share_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = DEF_N_REQ,
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned LATENCY = DEF_LATENCY,
  parameter int unsigned MAX_OUT = DEF_MAX_OUT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid_i,
  input  logic [N_REQ*WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ-1:0]       cfg_mask_i,
  output logic                   pipe_in_valid_o,
  output logic [WIDTH-1:0]       pipe_in_data_o,
  input  logic                   pipe_out_valid_i,
  input  logic [WIDTH-1:0]       pipe_out_data_i,
  output logic [N_REQ-1:0]       resp_valid_o,
  output logic [WIDTH-1:0]       resp_data_o,
  output logic                   err_desync_o
);

  localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             issue_valid_q, issue_valid_d;
  logic [ID_W-1:0]  issue_id_q, issue_id_d;
  logic [WIDTH-1:0] pipe_in_data_q, pipe_in_data_d;
  logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] out_cnt_q [N_REQ];
  logic [CNT_W-1:0] out_cnt_d [N_REQ];

  logic [N_REQ-1:0] elig_c;
  logic [N_REQ-1:0] gnt_oh_c;
  logic             gnt_any_c;
  logic [ID_W-1:0]  gnt_idx_c;
  logic [WIDTH-1:0] gnt_data_c;
  logic [ID_W:0]    scan_sum_c;

  pipe_tag_t        tag_push_c;
  pipe_tag_t        tag_head_c;
  logic             resp_fire_c;
  logic             desync_c;
  logic             cnt_err_c;
  logic [N_REQ-1:0] resp_oh_c;

  // Eligibility and round-robin search starting at rr_ptr, wrapping at N_REQ.
  always_comb begin
    elig_c     = '0;
    gnt_oh_c   = '0;
    gnt_any_c  = 1'b0;
    gnt_idx_c  = '0;
    gnt_data_c = '0;
    scan_sum_c = '0;

    for (int unsigned i = 0; i < N_REQ; i++) begin
      elig_c[i] = req_valid_i[i] & cfg_mask_i[i] & (out_cnt_q[i] < CNT_W'(MAX_OUT));
    end

    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_sum_c = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan_sum_c >= (ID_W+1)'(N_REQ)) begin
        scan_sum_c = scan_sum_c - (ID_W+1)'(N_REQ);
      end
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!gnt_any_c && elig_c[i] && (ID_W'(i) == scan_sum_c[ID_W-1:0])) begin
          gnt_any_c   = 1'b1;
          gnt_idx_c   = ID_W'(i);
          gnt_oh_c[i] = 1'b1;
          gnt_data_c  = req_data_i[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Issue side: the issue register is the first tag stage, so the line
  // behind it only needs LATENCY entries to meet the pipeline output.
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    issue_valid_d  = gnt_any_c;
    issue_id_d     = '0;
    pipe_in_data_d = pipe_in_data_q;
    if (gnt_any_c) begin
      rr_ptr_d       = rr_next(gnt_idx_c, N_REQ);
      issue_id_d     = gnt_idx_c;
      pipe_in_data_d = gnt_data_c;
    end
  end

  assign tag_push_c = '{valid: issue_valid_q, id: issue_id_q};

  tag_delay_line #(
    .DEPTH (LATENCY),
    .tag_t (pipe_tag_t)
  ) u_tag_line (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (tag_push_c),
    .head_o (tag_head_c)
  );

  // Return steering, desync detection and outstanding-credit bookkeeping.
  always_comb begin
    resp_fire_c  = tag_head_c.valid & pipe_out_valid_i;
    desync_c     = tag_head_c.valid ^ pipe_out_valid_i;
    resp_oh_c    = '0;
    cnt_err_c    = 1'b0;
    resp_data_d  = resp_data_q;

    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (resp_fire_c && (tag_head_c.id == ID_W'(i))) begin
        resp_oh_c[i] = 1'b1;
      end
    end
    if (resp_fire_c) begin
      resp_data_d = pipe_out_data_i;
    end
    resp_valid_d = resp_oh_c;

    // The credit is returned as the response strobe is registered, so a
    // requester at its limit may be granted again in its strobe cycle.
    for (int unsigned i = 0; i < N_REQ; i++) begin
      out_cnt_d[i] = out_cnt_q[i];
      case ({gnt_oh_c[i], resp_oh_c[i]})
        2'b10: out_cnt_d[i] = out_cnt_q[i] + CNT_W'(1);
        2'b01: begin
          if (out_cnt_q[i] == '0) begin
            cnt_err_c = 1'b1;
          end else begin
            out_cnt_d[i] = out_cnt_q[i] - CNT_W'(1);
          end
        end
        default: out_cnt_d[i] = out_cnt_q[i];
      endcase
    end

    err_d = err_q | desync_c | cnt_err_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q       <= '0;
      issue_valid_q  <= 1'b0;
      issue_id_q     <= '0;
      pipe_in_data_q <= '0;
      resp_valid_q   <= '0;
      resp_data_q    <= '0;
      err_q          <= 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        out_cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      issue_valid_q  <= issue_valid_d;
      issue_id_q     <= issue_id_d;
      pipe_in_data_q <= pipe_in_data_d;
      resp_valid_q   <= resp_valid_d;
      resp_data_q    <= resp_data_d;
      err_q          <= err_d;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        out_cnt_q[i] <= out_cnt_d[i];
      end
    end
  end

  assign req_ready_o     = gnt_oh_c;
  assign pipe_in_valid_o = issue_valid_q;
  assign pipe_in_data_o  = pipe_in_data_q;
  assign resp_valid_o    = resp_valid_q;
  assign resp_data_o     = resp_data_q;
  assign err_desync_o    = err_q;

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Scoreboard bench for pipe_share_arbiter: a queue-based reference model
// predicts grants and responses; a separate monitor checks returned results.
module tb_pipe_share_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 64;
  localparam int unsigned L  = 3;
  localparam int unsigned MO = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid, cfg_mask, req_ready, resp_valid;
  logic [N*W-1:0] req_data;
  logic           pipe_in_valid, pipe_out_valid, err_desync;
  logic [W-1:0]   pipe_in_data, pipe_out_data, resp_data;
  logic           inj;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int           id;
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  int           rr;
  logic         exp_piv;
  logic [W-1:0] exp_pid;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipe_share_arbiter #(
    .N_REQ   (N),
    .WIDTH   (W),
    .LATENCY (L),
    .MAX_OUT (MO)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid_i      (req_valid),
    .req_data_i       (req_data),
    .req_ready_o      (req_ready),
    .cfg_mask_i       (cfg_mask),
    .pipe_in_valid_o  (pipe_in_valid),
    .pipe_in_data_o   (pipe_in_data),
    .pipe_out_valid_i (pipe_out_valid),
    .pipe_out_data_i  (pipe_out_data),
    .resp_valid_o     (resp_valid),
    .resp_data_o      (resp_data),
    .err_desync_o     (err_desync)
  );

  // Environment pipeline: fixed latency, inverts the payload, reset with the DUT.
  logic         pv [L];
  logic [W-1:0] pd [L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L; i++) begin
        pv[i] <= 1'b0;
        pd[i] <= '0;
      end
    end else begin
      pv[0] <= pipe_in_valid;
      pd[0] <= pipe_in_data;
      for (int i = 1; i < L; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign pipe_out_valid = pv[L-1] | inj;
  assign pipe_out_data  = ~pd[L-1];

  function automatic void check(input string name, input logic [W-1:0] act,
                                input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic logic [N*W-1:0] rnd_data();
    logic [N*W-1:0] d;
    for (int i = 0; i < N*W/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference: outstanding = queued items not yet due; first eligible from rr.
  task automatic model_step();
    int           cnt [N];
    logic [N-1:0] exp_rdy;
    int           g;
    int           idx;
    check("pipe_in_valid", W'(pipe_in_valid), W'(exp_piv));
    check("pipe_in_data", pipe_in_data, exp_pid);
    for (int i = 0; i < N; i++) cnt[i] = 0;
    foreach (exp_q[j]) if (exp_q[j].due > cyc) cnt[exp_q[j].id]++;
    g = -1;
    for (int k = 0; k < N; k++) begin
      idx = (rr + k) % N;
      if (g < 0 && req_valid[idx] && cfg_mask[idx] && cnt[idx] < MO) g = idx;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", W'(req_ready), W'(exp_rdy));
    if (g >= 0) begin
      exp_t e;
      e.id   = g;
      e.data = req_data[g*W +: W];
      e.due  = cyc + 2 + L;
      exp_q.push_back(e);
      rr      = (g + 1) % N;
      exp_piv = 1'b1;
      exp_pid = e.data;
    end else begin
      exp_piv = 1'b0;
    end
  endtask

  // Entered and left at posedge+1; inputs change only there.
  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] m,
                       input logic [N*W-1:0] d);
    req_valid = v;
    cfg_mask  = m;
    req_data  = d;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '1, rnd_data());
  endtask

  task automatic model_reset();
    exp_q.delete();
    rr      = 0;
    exp_piv = 1'b0;
    exp_pid = '0;
  endtask

  // Monitor: every response strobe must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (rst_n && resp_valid !== '0) begin
      if (exp_q.size() == 0) begin
        check("resp_unexpected", W'(resp_valid), '0);
      end else begin
        exp_t e;
        logic [W-1:0] oh;
        e  = exp_q.pop_front();
        oh = W'(1) << e.id;
        check("resp_onehot", W'(resp_valid), oh);
        check("resp_data", resp_data, ~e.data);
        check("resp_cycle", W'(cyc), W'(e.due));
      end
    end
  end

  initial begin
    logic [N*W-1:0] d;
    rst_n     = 1'b0;
    inj       = 1'b0;
    req_valid = '0;
    cfg_mask  = '1;
    req_data  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_pipe_in_valid", W'(pipe_in_valid), '0);
    check("rst_pipe_in_data", pipe_in_data, '0);
    check("rst_resp_valid", W'(resp_valid), '0);
    check("rst_resp_data", resp_data, '0);
    check("rst_err", W'(err_desync), '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single requester, payload 0xA5.
    d = '0;
    d[7:0] = 8'hA5;
    drive(4'b0001, 4'b1111, d);
    idle(8);

    // All requesters valid: plain rotation.
    for (int i = 0; i < 16; i++) drive(4'b1111, 4'b1111, rnd_data());
    idle(8);

    // Only requester 2: credit limit stalls, refilled on strobe cycle.
    for (int i = 0; i < 14; i++) drive(4'b0100, 4'b1111, rnd_data());
    idle(8);

    // Requester 2 masked out.
    for (int i = 0; i < 12; i++) drive(4'b1111, 4'b1011, rnd_data());

    // Mask everything while items are still in flight.
    for (int i = 0; i < 4; i++) drive(4'b1111, 4'b1111, rnd_data());
    for (int i = 0; i < 8; i++) drive(4'b1111, 4'b0000, rnd_data());
    idle(4);

    // Random traffic, occasional random mask.
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] m;
      m = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      drive(N'($urandom), m, rnd_data());
    end
    idle(10);
    check("drain_empty", W'(exp_q.size()), '0);
    check("no_err_after_traffic", W'(err_desync), '0);

    // Spurious pipeline output with no tag.
    inj = 1'b1;
    drive('0, '1, rnd_data());
    inj = 1'b0;
    check("desync_set", W'(err_desync), W'(1));
    check("desync_no_resp", W'(resp_valid), '0);
    idle(5);
    check("desync_sticky", W'(err_desync), W'(1));
    #2 rst_n = 1'b0;
    #1;
    check("desync_cleared_by_reset", W'(err_desync), '0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    check("err_clear_after_release", W'(err_desync), '0);

    // Reset with three items in flight.
    for (int i = 0; i < 3; i++) drive(4'b1111, 4'b1111, rnd_data());
    #2 rst_n = 1'b0;
    #1;
    check("midrst_pipe_in_valid", W'(pipe_in_valid), '0);
    check("midrst_pipe_in_data", pipe_in_data, '0);
    check("midrst_resp_valid", W'(resp_valid), '0);
    check("midrst_resp_data", resp_data, '0);
    check("midrst_ready_from_0", W'(req_ready), W'(4'b0001));
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) drive(4'b1111, 4'b1111, rnd_data());
    idle(10);
    check("final_drain_empty", W'(exp_q.size()), '0);
    check("final_no_err", W'(err_desync), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
